// File: rtl/tdes_ahb_slave_ctrl.sv
// AHB-Lite slave register front end for a Triple-DES core: CTRL/KEY/DATA registers, result FIFO, status.
// Optional interrupt output and CTRL.irqEnable bit are built when TDES_AHB_IRQ_EN is defined.
module tdes_ahb_slave_ctrl #(
  parameter int          DATA_W    = 64,
  parameter int          NUM_KEYS  = 3,
  parameter logic [31:0] BASE_ADDR = 32'hAAAAAAA0,
  parameter int          RES_DEPTH = 4
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic                       HSEL,
  input  logic [31:0]                HADDR,
  input  logic                       HWRITE,
  input  logic [1:0]                 HTRANS,
  input  logic [2:0]                 HSIZE,
  input  logic [2:0]                 HBURST,
  input  logic [3:0]                 HPROT,
  input  logic                       HMASTLOCK,
  input  logic                       HREADY,
  input  logic [DATA_W-1:0]          HWDATA,
  output logic [DATA_W-1:0]          HRDATA,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  output logic                       enable,
  output logic                       encryptionType,
  output logic [DATA_W-1:0]          data,
  output logic [NUM_KEYS*DATA_W-1:0] keys,
  input  logic                       outputEnable,
  input  logic [DATA_W-1:0]          outputData
`ifdef TDES_AHB_IRQ_EN
  ,
  output logic                       irq
`endif
);

  localparam int NREG  = NUM_KEYS + 4;
  localparam int OFF_W = $clog2(NREG);
  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [OFF_W-1:0] CTRL_OFF = '0;
  localparam logic [OFF_W-1:0] DATA_OFF = OFF_W'(NUM_KEYS + 1);
  localparam logic [OFF_W-1:0] RES_OFF  = OFF_W'(NUM_KEYS + 2);
  localparam logic [OFF_W-1:0] STAT_OFF = OFF_W'(NUM_KEYS + 3);

  typedef enum logic [1:0] {IDLE, OKAY, ERR1, ERR2} state_t;

  state_t               state;
  logic                 write_p1;
  logic [OFF_W-1:0]     off_p1;
  logic [31:0]          off_p0;
  logic [OFF_W-1:0]     off_a;
  logic                 accept_p0, bad_p0;
  logic                 busy, ovf;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     rptr, wptr;
  logic [DATA_W-1:0]    mem [RES_DEPTH];
  logic [DATA_W-1:0]    key_q [NUM_KEYS];
  logic [DATA_W-1:0]    status_w;
  logic                 good_p1, reg_we, data_we, pop, push_ok, full, empty, stat_rd;
  logic                 busy_chk, empty_chk;
  logic                 irq_en;
  logic                 unused_bits;

  assign unused_bits = ^{HPROT, HTRANS[0]};

  assign off_p0    = HADDR - BASE_ADDR;
  assign off_a     = off_p0[OFF_W-1:0];
  assign accept_p0 = HSEL & HREADY & HTRANS[1] & (state != ERR1);

  assign good_p1 = (state == OKAY);
  assign reg_we  = good_p1 & write_p1;
  assign data_we = reg_we & (off_p1 == DATA_OFF);
  assign stat_rd = good_p1 & ~write_p1 & (off_p1 == STAT_OFF);
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(RES_DEPTH));
  assign pop     = good_p1 & ~write_p1 & (off_p1 == RES_OFF) & ~empty;
  assign push_ok = outputEnable & (~full | pop);

  // The address-phase checks must see the effect of the data phase still in flight.
  assign busy_chk  = busy | data_we;
  assign empty_chk = empty | ((count == CNT_W'(1)) & pop);

  always_comb begin
    bad_p0 = 1'b0;
    if (HSIZE != 3'b011 || HBURST != 3'b000 || HMASTLOCK)
      bad_p0 = 1'b1;
    if (off_p0 >= 32'(NREG)) begin
      bad_p0 = 1'b1;
    end else begin
      if (HWRITE && (off_a == RES_OFF || off_a == STAT_OFF)) bad_p0 = 1'b1;
      if (HWRITE && off_a == DATA_OFF && busy_chk)           bad_p0 = 1'b1;
      if (!HWRITE && off_a == RES_OFF && empty_chk)          bad_p0 = 1'b1;
    end
  end

  // Address phase -> data phase
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state     <= IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      write_p1  <= 1'b0;
      off_p1    <= '0;
    end else begin
      case (state)
        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          if (accept_p0) begin
            write_p1 <= HWRITE;
            off_p1   <= off_a;
            if (bad_p0) begin
              state     <= ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else begin
              state     <= OKAY;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
            end
          end else begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Data phase commit
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      encryptionType <= 1'b0;
      irq_en         <= 1'b0;
      data           <= '0;
      enable         <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) key_q[k] <= '0;
    end else begin
      enable <= data_we;
      if (reg_we) begin
        if (off_p1 == CTRL_OFF) begin
          encryptionType <= HWDATA[0];
`ifdef TDES_AHB_IRQ_EN
          irq_en <= HWDATA[1];
`endif
        end
        for (int k = 0; k < NUM_KEYS; k++)
          if (off_p1 == OFF_W'(k + 1)) key_q[k] <= HWDATA;
        if (off_p1 == DATA_OFF) data <= HWDATA;
      end
    end
  end

  always_comb begin
    keys = '0;
    for (int k = 0; k < NUM_KEYS; k++) keys[k*DATA_W +: DATA_W] = key_q[k];
  end

  // Result FIFO control; a push into a full FIFO survives only if a pop frees a slot
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      if (pop)     rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (outputEnable && full && !pop) ovf <= 1'b1;
      else if (stat_rd)                 ovf <= 1'b0;
      if (data_we)           busy <= 1'b1;
      else if (outputEnable) busy <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wptr] <= outputData;
  end

`ifdef TDES_AHB_IRQ_EN
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) irq <= 1'b0;
    else         irq <= (irq_en & ~empty) | (irq_en & ovf);
  end
`endif

  always_comb begin
    status_w             = '0;
    status_w[0]          = busy;
    status_w[1]          = empty;
    status_w[2]          = full;
    status_w[3]          = ovf;
    status_w[8 +: CNT_W] = count;
    HRDATA               = '0;
    if (good_p1 && !write_p1) begin
      if (off_p1 == CTRL_OFF) begin
        HRDATA[0] = encryptionType;
        HRDATA[1] = irq_en;
      end
      for (int k = 0; k < NUM_KEYS; k++)
        if (off_p1 == OFF_W'(k + 1)) HRDATA = key_q[k];
      if (off_p1 == DATA_OFF) HRDATA = data;
      if (off_p1 == RES_OFF)  HRDATA = mem[rptr];
      if (off_p1 == STAT_OFF) HRDATA = status_w;
    end
  end

endmodule

// File: tb/tb_tdes_ahb_slave_ctrl.sv
// Directed self-checking bench for tdes_ahb_slave_ctrl (default NUM_KEYS=3, RES_DEPTH=4).
module tb_tdes_ahb_slave_ctrl;
  localparam logic [31:0] BA     = 32'hAAAAAAA0;
  localparam logic [31:0] A_CTRL = BA;
  localparam logic [31:0] A_K1   = BA + 32'd1;
  localparam logic [31:0] A_K2   = BA + 32'd2;
  localparam logic [31:0] A_K3   = BA + 32'd3;
  localparam logic [31:0] A_DATA = BA + 32'd4;
  localparam logic [31:0] A_RES  = BA + 32'd5;
  localparam logic [31:0] A_STAT = BA + 32'd6;
  localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h23456789ABCDEF01;
  localparam logic [63:0] K3 = 64'h456789ABCDEF0123;
  localparam logic [63:0] PT = 64'h4E6F772069732074;
  localparam logic [63:0] CT = 64'h3FA40E8A984D4815;

  logic         HCLK = 1'b0, HRESET = 1'b0;
  logic         HSEL = 1'b0, HWRITE = 1'b0, HMASTLOCK = 1'b0, HREADY;
  logic [31:0]  HADDR = '0;
  logic [1:0]   HTRANS = '0;
  logic [2:0]   HSIZE = 3'b011, HBURST = '0;
  logic [3:0]   HPROT = 4'h3;
  logic [63:0]  HWDATA = '0, HRDATA;
  logic         HREADYOUT, HRESP;
  logic         enable, encryptionType, outputEnable = 1'b0;
  logic [63:0]  data, outputData = '0;
  logic [191:0] keys;
`ifdef TDES_AHB_IRQ_EN
  logic         irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] rd;
  logic        r1, p1, r2, p2;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  tdes_ahb_slave_ctrl dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .enable(enable),
    .encryptionType(encryptionType), .data(data), .keys(keys),
    .outputEnable(outputEnable), .outputData(outputData)
`ifdef TDES_AHB_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic tick;
    @(posedge HCLK); #1;
  endtask

  // One single-beat transfer; response of the first and (on error) second data-phase cycle.
  task automatic ahb(input logic wr, input logic [31:0] a, input logic [63:0] wd, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = sz;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b011; HWDATA = wd;
    @(negedge HCLK);
    rd = HRDATA; r1 = HREADYOUT; p1 = HRESP; r2 = 1'b1; p2 = 1'b0;
    if (!r1) begin
      @(posedge HCLK); @(negedge HCLK);
      r2 = HREADYOUT; p2 = HRESP;
    end
    @(posedge HCLK); #1;
  endtask

  task automatic wr64(input logic [31:0] a, input logic [63:0] d);
    ahb(1'b1, a, d, 3'b011);
  endtask

  task automatic rd64(input logic [31:0] a);
    ahb(1'b0, a, 64'h0, 3'b011);
  endtask

  task automatic push(input logic [63:0] d);
    outputEnable = 1'b1; outputData = d;
    tick();
    outputEnable = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hreadyout: got %b want 1", HREADYOUT); end
    checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL rst_hresp: got %b want 0", HRESP); end
    checks++; if ({enable, encryptionType, HRDATA, data, keys} !== '0) begin errors++; $display("FAIL rst_outputs: got en=%b enc=%b rdata=%h data=%h keys=%h want all 0", enable, encryptionType, HRDATA, data, keys); end
    HRESET = 1'b1;
    rd64(A_STAT);
    checks++; if ({r1, p1, rd} !== {2'b10, 64'h2}) begin errors++; $display("FAIL rst_status: got rdy=%b resp=%b %h want rdy=1 resp=0 0000000000000002", r1, p1, rd); end
  endtask

  task automatic test_basic;
    wr64(A_CTRL, 64'h1);
    checks++; if ({r1, p1} !== 2'b10) begin errors++; $display("FAIL ctrl_wr_resp: got rdy=%b resp=%b want rdy=1 resp=0", r1, p1); end
    wr64(A_K1, K1); wr64(A_K2, K2); wr64(A_K3, K3);
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL enable_idle: got %b want 0", enable); end
    wr64(A_DATA, PT);
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL enable_pulse: got %b want 1", enable); end
    tick();
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL enable_width: got %b want 0", enable); end
    checks++; if (keys !== {K3, K2, K1}) begin errors++; $display("FAIL keys: got %h want %h", keys, {K3, K2, K1}); end
    checks++; if (data !== PT) begin errors++; $display("FAIL data: got %h want %h", data, PT); end
    checks++; if (encryptionType !== 1'b1) begin errors++; $display("FAIL enc_type: got %b want 1", encryptionType); end
    rd64(A_STAT);
    checks++; if (rd !== 64'h3) begin errors++; $display("FAIL status_busy: got %h want 0000000000000003", rd); end
    wr64(A_DATA, 64'h1111);
    checks++; if ({r1, p1, r2, p2} !== 4'b0111) begin errors++; $display("FAIL data_busy_err: got %b%b%b%b want 0111", r1, p1, r2, p2); end
    checks++; if ({data, enable} !== {PT, 1'b0}) begin errors++; $display("FAIL data_busy_kept: got %h en=%b want %h en=0", data, enable, PT); end
  endtask

  task automatic test_result;
    push(CT);
    rd64(A_RES);
    checks++; if (rd !== CT) begin errors++; $display("FAIL result_data: got %h want %h", rd, CT); end
    checks++; if ({r1, p1} !== 2'b10) begin errors++; $display("FAIL result_resp: got rdy=%b resp=%b want rdy=1 resp=0", r1, p1); end
    rd64(A_STAT);
    checks++; if (rd !== 64'h2) begin errors++; $display("FAIL status_empty: got %h want 0000000000000002", rd); end
  endtask

  task automatic test_errors;
    rd64(A_RES);
    checks++; if ({r1, p1, r2, p2} !== 4'b0111) begin errors++; $display("FAIL err_empty_read: got %b%b%b%b want 0111", r1, p1, r2, p2); end
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL err_rdata: got %h want 0", rd); end
    ahb(1'b1, A_CTRL, 64'h0, 3'b010);
    checks++; if ({r1, p1, r2, p2} !== 4'b0111) begin errors++; $display("FAIL err_hsize: got %b%b%b%b want 0111", r1, p1, r2, p2); end
    wr64(BA + 32'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if ({r1, p1, r2, p2} !== 4'b0111) begin errors++; $display("FAIL err_addr: got %b%b%b%b want 0111", r1, p1, r2, p2); end
    rd64(A_CTRL);
    checks++; if (rd !== 64'h1) begin errors++; $display("FAIL err_ctrl_kept: got %h want 0000000000000001", rd); end
    checks++; if ({keys, data} !== {K3, K2, K1, PT}) begin errors++; $display("FAIL err_regs_kept: got %h %h", keys, data); end
  endtask

  task automatic test_overflow;
    outputEnable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      outputData = 64'hC0DE_0000_0000_0000 + 64'(i);
      tick();
    end
    outputEnable = 1'b0;
    rd64(A_STAT);
    checks++; if (rd !== 64'h40C) begin errors++; $display("FAIL ovf_status: got %h want 000000000000040c", rd); end
    rd64(A_STAT);
    checks++; if (rd !== 64'h404) begin errors++; $display("FAIL ovf_cleared: got %h want 0000000000000404", rd); end
    for (int i = 0; i < 4; i++) begin
      rd64(A_RES);
      checks++; if (rd !== 64'hC0DE_0000_0000_0000 + 64'(i)) begin errors++; $display("FAIL ovf_order%0d: got %h want %h", i, rd, 64'hC0DE_0000_0000_0000 + 64'(i)); end
    end
    rd64(A_STAT);
    checks++; if (rd !== 64'h2) begin errors++; $display("FAIL ovf_drained: got %h want 0000000000000002", rd); end
  endtask

  task automatic test_push_pop_full;
    outputEnable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      outputData = 64'hF0F0_0000_0000_0000 + 64'(i);
      tick();
    end
    outputEnable = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = A_RES; HWRITE = 1'b0;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    outputEnable = 1'b1; outputData = 64'hF0F0_0000_0000_0004;
    @(negedge HCLK); rd = HRDATA;
    tick();
    outputEnable = 1'b0;
    checks++; if (rd !== 64'hF0F0_0000_0000_0000) begin errors++; $display("FAIL pp_pop: got %h want f0f0000000000000", rd); end
    rd64(A_STAT);
    checks++; if (rd !== 64'h404) begin errors++; $display("FAIL pp_status: got %h want 0000000000000404", rd); end
    for (int i = 1; i < 5; i++) begin
      rd64(A_RES);
      checks++; if (rd !== 64'hF0F0_0000_0000_0000 + 64'(i)) begin errors++; $display("FAIL pp_order%0d: got %h want %h", i, rd, 64'hF0F0_0000_0000_0000 + 64'(i)); end
    end
  endtask

  task automatic test_ctrl_bit1;
    wr64(A_CTRL, 64'h3);
    rd64(A_CTRL);
`ifdef TDES_AHB_IRQ_EN
    checks++; if (rd !== 64'h3) begin errors++; $display("FAIL ctrl_irqen: got %h want 0000000000000003", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
    push(CT);
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
    rd64(A_RES);
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr: got %b want 0", irq); end
`else
    checks++; if (rd !== 64'h1) begin errors++; $display("FAIL ctrl_bit1: got %h want 0000000000000001", rd); end
`endif
    wr64(A_CTRL, 64'h1);
  endtask

  task automatic test_reset_midwrite;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = A_K2; HWRITE = 1'b1;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 64'hDEAD_BEEF_DEAD_BEEF;
    #2 HRESET = 1'b0;
    #1;
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL mid_rst_resp: got rdy=%b resp=%b want rdy=1 resp=0", HREADYOUT, HRESP); end
    checks++; if ({enable, encryptionType, HRDATA, data, keys} !== '0) begin errors++; $display("FAIL mid_rst_outputs: got enc=%b data=%h keys=%h want 0", encryptionType, data, keys); end
    @(negedge HCLK);
    HRESET = 1'b1;
    wr64(A_CTRL, 64'h1);
    checks++; if ({r1, p1, encryptionType} !== 3'b101) begin errors++; $display("FAIL post_rst_ctrl: got rdy=%b resp=%b enc=%b want 1 0 1", r1, p1, encryptionType); end
    checks++; if (keys !== '0) begin errors++; $display("FAIL post_rst_keys: got %h want 0", keys); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_result();
    test_errors();
    test_overflow();
    test_push_pop_full();
    test_ctrl_bit1();
    test_reset_midwrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end
endmodule
